// File: rtl/byte_issue_sched_if.sv
// byte_issue_sched_if: two requester ports, branch/drain control and the Byte-unit issue bundle.
interface byte_issue_sched_if;
  logic req0_valid, req1_valid;
  logic req0_ready, req1_ready;
  logic [0:10] req0_op, req1_op;
  logic [0:6] req0_rt, req0_ra, req0_rb;
  logic [0:6] req1_rt, req1_ra, req1_rb;
  logic req0_we, req1_we;
  logic branch_is_taken;
  logic drain_req;
  logic drained;
  logic issue_valid;
  logic [0:10] issue_op_code;
  logic [0:2] issue_format;
  logic [0:6] issue_rt;
  logic issue_we;
  logic issue_src;
  logic err_illegal;
  modport master (
    output req0_valid, req1_valid, req0_op, req1_op, req0_rt, req0_ra, req0_rb,
    output req1_rt, req1_ra, req1_rb, req0_we, req1_we, branch_is_taken, drain_req,
    input req0_ready, req1_ready, drained, issue_valid, issue_op_code, issue_format,
    input issue_rt, issue_we, issue_src, err_illegal
  );
  modport slave (
    input req0_valid, req1_valid, req0_op, req1_op, req0_rt, req0_ra, req0_rb,
    input req1_rt, req1_ra, req1_rb, req0_we, req1_we, branch_is_taken, drain_req,
    output req0_ready, req1_ready, drained, issue_valid, issue_op_code, issue_format,
    output issue_rt, issue_we, issue_src, err_illegal
  );
endinterface

// File: rtl/byte_issue_sched.sv
// byte_issue_sched: round-robin issue scheduler for the Byte unit with RAW scoreboard, branch kill and drain.
// Optional BYTE_SCHED_FWD_EN: the oldest scoreboard entry is left out of the hazard check (wb forwarding covers it).
module byte_issue_sched #(
  parameter int LATENCY = 3
) (
  input logic clock,
  input logic reset,
  byte_issue_sched_if.slave bus
);
  localparam int DEPTH = LATENCY + 1;
`ifdef BYTE_SCHED_FWD_EN
  localparam int HZ_N = LATENCY;
`else
  localparam int HZ_N = DEPTH;
`endif
  localparam logic [0:10] OP_CNTB = 11'b01010110100;
  localparam logic [0:10] OP_AVGB = 11'b00011010011;
  localparam logic [0:10] OP_ABSDB = 11'b00001010011;
  localparam logic [0:10] OP_SUMB = 11'b01001010011;
  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;
  typedef struct packed {
    logic v;
    logic [0:6] rt;
    logic we;
  } sb_t;
  state_t state_q, state_d;
  sb_t [DEPTH-1:0] sb_q, sb_d;
  logic rr_q, rr_d, iv_q, iv_d, we_q, we_d, src_q, src_d, err_q, err_d;
  logic [0:10] op_q, op_d;
  logic [0:6] rt_q, rt_d;
  logic [0:10] op [2];
  logic [0:6] rt [2];
  logic [0:6] ra [2];
  logic [0:6] rb [2];
  logic [1:0] vld, wr, hz, elig;
  logic sel, acc, legal, empty, kill, live;
  logic [0:10] a_op;
  logic [0:6] a_rt;
  logic a_we;
  assign op[0] = bus.req0_op;
  assign op[1] = bus.req1_op;
  assign rt[0] = bus.req0_rt;
  assign rt[1] = bus.req1_rt;
  assign ra[0] = bus.req0_ra;
  assign ra[1] = bus.req1_ra;
  assign rb[0] = bus.req0_rb;
  assign rb[1] = bus.req1_rb;
  assign vld = {bus.req1_valid, bus.req0_valid};
  assign wr = {bus.req1_we, bus.req0_we};
  assign kill = bus.branch_is_taken;
  // cntb has a single source operand, so its rb field never creates a hazard
  always_comb begin
    hz = '0;
    empty = 1'b1;
    for (int k = 0; k < DEPTH; k++) empty = empty & ~sb_q[k].v;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < HZ_N; k++)
        hz[r] = hz[r] | (sb_q[k].v & sb_q[k].we &
                ((sb_q[k].rt == ra[r]) | ((op[r] != OP_CNTB) & (sb_q[k].rt == rb[r]))));
  end
  always_comb begin
    elig = vld & ~hz & {2{reset & (state_q == RUN) & ~kill}};
    acc = |elig;
    sel = &elig ? rr_q : elig[1];
    a_op = op[sel];
    a_rt = rt[sel];
    a_we = wr[sel];
    legal = (a_op == OP_CNTB) | (a_op == OP_AVGB) | (a_op == OP_ABSDB) | (a_op == OP_SUMB);
    rr_d = acc ? ~sel : rr_q;
    iv_d = acc & legal;
    err_d = acc & ~legal;
    op_d = iv_d ? a_op : op_q;
    rt_d = iv_d ? a_rt : rt_q;
    we_d = iv_d ? a_we : we_q;
    src_d = iv_d ? sel : src_q;
    sb_d = {sb_q[DEPTH-2:0], sb_t'{v: iv_d, rt: a_rt, we: a_we}};
    sb_d[1].v = sb_q[0].v & ~kill;
    state_d = state_q == RUN ? (bus.drain_req ? DRAIN : RUN)
            : state_q == DRAIN ? (!bus.drain_req ? RUN : (empty & ~iv_q) ? DRAINED : DRAIN)
            : (bus.drain_req ? DRAINED : RUN);
  end
  always_ff @(posedge clock)
    if (!reset) begin
      state_q <= RUN;
      sb_q <= '0;
      rr_q <= 1'b0;
      iv_q <= 1'b0;
      we_q <= 1'b0;
      src_q <= 1'b0;
      err_q <= 1'b0;
      op_q <= '0;
      rt_q <= '0;
    end else begin
      state_q <= state_d;
      sb_q <= sb_d;
      rr_q <= rr_d;
      iv_q <= iv_d;
      we_q <= we_d;
      src_q <= src_d;
      err_q <= err_d;
      op_q <= op_d;
      rt_q <= rt_d;
    end
  assign live = iv_q & ~kill;
  assign bus.req0_ready = acc & ~sel;
  assign bus.req1_ready = sel;
  assign bus.issue_valid = live;
  assign bus.issue_op_code = live ? op_q : '0;
  assign bus.issue_format = '0;
  assign bus.issue_rt = rt_q;
  assign bus.issue_we = we_q & live;
  assign bus.issue_src = src_q;
  assign bus.err_illegal = err_q;
  assign bus.drained = state_q == DRAINED;
endmodule

// File: tb/tb_byte_issue_sched.sv
// tb_byte_issue_sched: directed table, hand sequences and random traffic,
// all checked against a producer-list reference model of the scheduler.
module tb_byte_issue_sched;
  localparam int LAT = 3;
`ifdef BYTE_SCHED_FWD_EN
  localparam int BLK = LAT;
`else
  localparam int BLK = LAT + 1;
`endif
  localparam logic [0:10] CNTB = 11'b01010110100;
  localparam logic [0:10] AVGB = 11'b00011010011;
  localparam logic [0:10] ABSDB = 11'b00001010011;
  localparam logic [0:10] SUMB = 11'b01001010011;
  localparam logic [0:10] ILL = 11'b00000000001;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  byte_issue_sched_if bus ();
  byte_issue_sched #(.LATENCY(LAT)) dut (.clock(clock), .reset(reset), .bus(bus));
  typedef struct {int c; logic [0:6] rt; bit we; bit killed;} prod_t;
  typedef struct {bit v; logic [0:10] op; logic [0:6] rt; logic [0:6] ra; logic [0:6] rb; bit we;} req_t;
  typedef struct {bit rs, v0, v1, br, dr, r0, r1, iv, src, drd;} vec_t;
  prod_t prods[$];
  int cyc = 0, checks = 0, errors = 0, mst = 0;
  bit mrr, m_iv, m_we, m_src, m_err, g_any, g_sel;
  logic [0:10] m_op = '0;
  logic [0:6] m_rt = '0;
  bit obs_r0, obs_r1, obs_iv, obs_src, obs_err, obs_dr;
  vec_t tbl [19];
  req_t idle, p0, p1, qa, qb;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  // a legal accept occupies cycles c+1..c+LAT+1; a branch kill leaves only c+1
  function automatic bit alive(prod_t p, int x);
    return x >= p.c + 1 && x <= p.c + LAT + 1 && (!p.killed || x == p.c + 1);
  endfunction
  function automatic bit hazard(logic [0:10] op, logic [0:6] ra, logic [0:6] rb);
    foreach (prods[i])
      if (alive(prods[i], cyc) && prods[i].we && cyc - prods[i].c <= BLK &&
          (prods[i].rt == ra || (op != CNTB && prods[i].rt == rb))) return 1'b1;
    return 1'b0;
  endfunction
  function automatic req_t mk(bit v, logic [0:10] op, int rt, int ra, int rb, bit we);
    req_t q;
    q.v = v; q.op = op; q.rt = 7'(rt); q.ra = 7'(ra); q.rb = 7'(rb); q.we = we;
    return q;
  endfunction
  function automatic req_t rnd_req();
    int s;
    s = $urandom_range(0, 9);
    return mk($urandom_range(0, 3) != 0,
              s < 3 ? CNTB : s < 5 ? AVGB : s < 7 ? ABSDB : s < 9 ? SUMB : ILL,
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 3) != 0);
  endfunction
  task automatic drive(input req_t a, input req_t b);
    bus.req0_valid = a.v; bus.req0_op = a.op; bus.req0_rt = a.rt;
    bus.req0_ra = a.ra; bus.req0_rb = a.rb; bus.req0_we = a.we;
    bus.req1_valid = b.v; bus.req1_op = b.op; bus.req1_rt = b.rt;
    bus.req1_ra = b.ra; bus.req1_rb = b.rb; bus.req1_we = b.we;
  endtask
  // one clock: compare at the falling edge, advance the model at the rising edge
  task automatic step();
    bit e0, e1, run, br, dr, rs, emp, ev, gwe;
    logic [0:10] gop;
    logic [0:6] grt;
    #4;
    br = bus.branch_is_taken; dr = bus.drain_req; rs = reset;
    run = rs && mst == 0 && !br;
    e0 = bus.req0_valid && run && !hazard(bus.req0_op, bus.req0_ra, bus.req0_rb);
    e1 = bus.req1_valid && run && !hazard(bus.req1_op, bus.req1_ra, bus.req1_rb);
    g_any = e0 || e1;
    g_sel = (e0 && e1) ? mrr : e1;
    ev = m_iv && !br;
    obs_r0 = bus.req0_ready; obs_r1 = bus.req1_ready; obs_iv = bus.issue_valid;
    obs_src = bus.issue_src; obs_err = bus.err_illegal; obs_dr = bus.drained;
    chk("req0_ready", obs_r0, g_any && !g_sel);
    chk("req1_ready", obs_r1, g_sel);
    chk("issue_valid", obs_iv, ev);
    chk("issue_op_code", bus.issue_op_code, ev ? m_op : 11'd0);
    chk("issue_format", bus.issue_format, 0);
    chk("issue_rt", bus.issue_rt, m_rt);
    chk("issue_we", bus.issue_we, m_we && ev);
    chk("issue_src", obs_src, m_src);
    chk("err_illegal", obs_err, m_err);
    chk("drained", obs_dr, mst == 2);
    gop = g_sel ? bus.req1_op : bus.req0_op;
    grt = g_sel ? bus.req1_rt : bus.req0_rt;
    gwe = g_sel ? bus.req1_we : bus.req0_we;
    emp = 1'b1;
    foreach (prods[i]) if (alive(prods[i], cyc)) emp = 1'b0;
    @(posedge clock);
    if (!rs) begin
      prods.delete();
      mst = 0; mrr = 0; m_iv = 0; m_we = 0; m_src = 0; m_err = 0; m_op = '0; m_rt = '0;
    end else begin
      if (br) foreach (prods[i]) if (prods[i].c == cyc - 1) prods[i].killed = 1'b1;
      m_iv = 0; m_err = 0;
      if (g_any) begin
        if (gop inside {CNTB, AVGB, ABSDB, SUMB}) begin
          prods.push_back('{cyc, grt, gwe, 1'b0});
          m_iv = 1; m_op = gop; m_rt = grt; m_we = gwe; m_src = g_sel;
        end else m_err = 1;
        mrr = !g_sel;
      end
      mst = mst == 0 ? (dr ? 1 : 0) : mst == 1 ? (!dr ? 0 : (emp ? 2 : 1)) : (dr ? 2 : 0);
    end
    cyc++;
    while (prods.size() > 0 && prods[0].c < cyc - 8) void'(prods.pop_front());
    #1;
  endtask
  task automatic do_reset();
    drive(idle, idle);
    bus.branch_is_taken = 0; bus.drain_req = 0;
    reset = 0; step(); reset = 1;
  endtask
  task automatic dep_test(input bit pwe, input int want, input string name);
    int k;
    do_reset();
    drive(mk(1, AVGB, 5, 30, 31, pwe), idle);
    step();
    chk({name, "_producer"}, obs_r0, 1);
    drive(idle, mk(1, ABSDB, 6, 5, 40, 1));
    k = 1;
    step();
    while (!obs_r1 && k < 12) begin k++; step(); end
    chk(name, k, want);
    drive(idle, idle);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    idle = mk(0, AVGB, 0, 0, 0, 0);
    p0 = mk(1, AVGB, 1, 20, 21, 1);
    p1 = mk(1, SUMB, 2, 22, 23, 1);
    tbl = '{'{0,1,1,0,0, 0,0,0,0,0}, '{0,1,1,0,0, 0,0,0,0,0},
            '{1,1,1,0,0, 1,0,0,0,0}, '{1,1,1,0,0, 0,1,1,0,0},
            '{1,1,1,0,0, 1,0,1,1,0}, '{1,1,1,0,0, 0,1,1,0,0},
            '{1,1,1,0,0, 1,0,1,1,0}, '{1,1,1,1,0, 0,0,0,0,0},
            '{1,1,1,0,0, 0,1,0,0,0}, '{1,1,1,0,0, 1,0,1,1,0},
            '{1,1,1,0,1, 0,1,1,0,0}, '{1,1,1,0,1, 0,0,1,1,0},
            '{1,1,1,0,1, 0,0,0,1,0}, '{1,1,1,0,1, 0,0,0,1,0},
            '{1,1,1,0,1, 0,0,0,1,0}, '{1,1,1,0,1, 0,0,0,1,0},
            '{1,1,1,0,1, 0,0,0,1,1}, '{1,1,1,0,0, 0,0,0,1,1},
            '{1,1,1,0,0, 1,0,0,1,0}};
    drive(idle, idle);
    bus.branch_is_taken = 0; bus.drain_req = 0;
    @(posedge clock); #1;
    for (int i = 0; i < 19; i++) begin
      reset = tbl[i].rs;
      p0.v = tbl[i].v0; p1.v = tbl[i].v1;
      drive(p0, p1);
      bus.branch_is_taken = tbl[i].br; bus.drain_req = tbl[i].dr;
      step();
      chk($sformatf("tbl%0d_req0_ready", i), obs_r0, tbl[i].r0);
      chk($sformatf("tbl%0d_req1_ready", i), obs_r1, tbl[i].r1);
      chk($sformatf("tbl%0d_issue_valid", i), obs_iv, tbl[i].iv);
      chk($sformatf("tbl%0d_issue_src", i), obs_src, tbl[i].src);
      chk($sformatf("tbl%0d_drained", i), obs_dr, tbl[i].drd);
    end
    dep_test(1, BLK + 1, "raw_first_dep_grant");
    dep_test(0, 1, "we0_dep_grant");
    do_reset();
    drive(mk(1, ILL, 7, 30, 31, 1), idle);
    step();
    chk("illegal_accept", obs_r0, 1);
    drive(idle, mk(1, AVGB, 8, 7, 7, 1));
    step();
    chk("illegal_err", obs_err, 1);
    chk("illegal_no_issue", obs_iv, 0);
    chk("illegal_no_block", obs_r1, 1);
    drive(idle, idle);
    step();
    chk("illegal_err_pulse", obs_err, 0);
    chk("illegal_dep_issue", obs_iv, 1);
    do_reset();
    drive(mk(1, CNTB, 9, 30, 31, 1), idle);
    step();
    drive(idle, mk(1, AVGB, 10, 9, 32, 1));
    bus.branch_is_taken = 1;
    step();
    chk("branch_kill_iv", obs_iv, 0);
    chk("branch_no_grant", obs_r1, 0);
    bus.branch_is_taken = 0;
    step();
    chk("branch_dep_grant", obs_r1, 1);
    do_reset();
    drive(mk(1, AVGB, 9, 30, 31, 1), idle);
    step();
    drive(idle, mk(1, CNTB, 11, 33, 9, 1));
    step();
    chk("cntb_rb_ignored", obs_r1, 1);
    drive(idle, mk(1, CNTB, 12, 11, 34, 1));
    step();
    chk("cntb_ra_blocked", obs_r1, 0);
    do_reset();
    drive(mk(1, AVGB, 5, 30, 31, 1), idle);
    step();
    drive(idle, mk(1, ABSDB, 6, 5, 40, 1));
    reset = 0;
    step();
    chk("reset_no_grant", obs_r1, 0);
    reset = 1;
    step();
    chk("reset_first_grant", obs_r1, 1);
    do_reset();
    qa = idle; qb = idle;
    for (int n = 0; n < 3000; n++) begin
      if (!qa.v || (g_any && !g_sel)) qa = rnd_req();
      if (!qb.v || (g_any && g_sel)) qb = rnd_req();
      drive(qa, qb);
      bus.branch_is_taken = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 39) == 0) bus.drain_req = !bus.drain_req;
      reset = $urandom_range(0, 199) != 0;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/byte_issue_sched.md
# byte_issue_sched

Issue scheduler for the Byte execution unit (cntb, avgb, absdb, sumb). Arbitrates round-robin between two instruction requesters, blocks read-after-write hazards against results still in flight through the Byte pipeline, and drives the Byte unit's op/format/destination/write-enable inputs from a register stage. Also provides a drain handshake for context switch, and kills the instruction being issued when a branch is taken.

## Interface
- LATENCY, 3: Byte unit cycles from capture of issue_* to wb_data valid.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; state is cleared on a clock edge with reset==0.
- req0_valid, req1_valid  in  1  requester has an instruction.
- req0_ready, req1_ready  out  1  grant; transfer occurs when valid and ready are both 1.
- req0_op, req1_op  in  11  RR-format opcode, bit order [0:10].
- req0_rt, req1_rt  in  7  destination register, [0:6].
- req0_ra, req0_rb, req1_ra, req1_rb  in  7  source register addresses.
- req0_we, req1_we  in  1  instruction writes RegTable.
- branch_is_taken  in  1  kill the instruction on issue_* this cycle.
- drain_req  in  1  level request to quiesce.
- drained  out  1  no issue and scoreboard empty.
- issue_valid  out  1  issue_* holds a live instruction.
- issue_op_code  out  11  to Byte op_code; 0 when not valid.
- issue_format  out  3  to Byte instr_format; always 0.
- issue_rt  out  7  to Byte dest_reg_addr.
- issue_we  out  1  to Byte enable_reg_write.
- issue_src  out  1  granted requester, used by the operand mux.
- err_illegal  out  1  one-cycle pulse: an accepted opcode was not a Byte op.

## Operation
- Legal opcodes: cntb 01010110100, avgb 00011010011, absdb 00001010011, sumb 01001010011.
- Eligibility: requester valid; not blocked by a hazard; FSM in RUN; branch_is_taken==0.
- Arbitration: at most one grant per cycle. When both requesters are eligible, the grant goes to rr_ptr; after any grant, rr_ptr points to the other requester.
- Hazard: ra or rb equals rt of any scoreboard entry with we=1. cntb checks only ra. Entries with we=0 never block.
- Scoreboard: shift register of depth LATENCY+1 holding {valid, rt, we}. An accept writes entry[0]; every entry shifts by one each cycle; the last entry retires.
- Legal accept: issue_* is loaded at the next edge with op, rt, we, src; issue_valid=1.
- Illegal accept: the instruction is consumed; err_illegal=1 the next cycle; issue_valid=0; no scoreboard entry is created.
- branch_is_taken: issue_valid is forced to 0 combinationally; entry[0] is invalidated at the edge; older entries are kept, because the Byte unit has already captured them; no grant that cycle.
- FSM:
  - RUN: grants allowed. Moves to DRAIN when drain_req=1.
  - DRAIN: no grants. Moves to DRAINED when the scoreboard is empty and issue_valid=0.
  - DRAINED: drained=1. Returns to RUN when drain_req=0.
  - A drain_req drop while in DRAIN returns to RUN.

## Timing
- Accept in cycle t: issue_* valid in t+1; Byte result on wb in t+1+LATENCY.
- Producer with we=1 accepted in cycle 0 (LATENCY=3): dependents are blocked in cycles 1–4; the earliest dependent accept is cycle 5.
- Ready may depend on the same-cycle valid. Requesters hold valid and payload stable until accepted.
- Reset values: all ready outputs 0, issue_valid 0, issue_op_code 0, issue_format 0, issue_rt 0, issue_we 0, issue_src 0, err_illegal 0, drained 0, FSM RUN, rr_ptr 0, scoreboard all invalid.
- Reset mid-operation: everything in flight is discarded; the first grant is possible in the first cycle after reset deasserts.
- Simultaneous drain_req and valid in RUN: the grant in that cycle still occurs; DRAIN starts at the next edge.

## Configuration
- BYTE_SCHED_FWD_EN
  - Defined: the oldest scoreboard entry (index LATENCY) is excluded from the hazard check, because the wb-to-issue forward path covers it. Dependent accept becomes possible in cycle 4.
  - Undefined: all entries are checked; dependent accept in cycle 5.

## Test plan
- Reset held low 2 cycles with both valids high → no ready; after release, req0 granted first, then req1; issue_src sequence 0,1.
- Both requesters continuously valid with independent registers → grants alternate 0,1,0,1 and issue_valid stays 1 every cycle.
- req0 avgb rt=5, we=1 at cycle 0; req1 absdb ra=5 from cycle 1 → req1_ready first high at cycle 5; with BYTE_SCHED_FWD_EN, at cycle 4.
- Same as the previous test but producer we=0 → dependent granted at cycle 1.
- req0_op=00000000001 accepted → err_illegal=1 for one cycle, issue_valid=0, a following dependent on that rt is not blocked.
- Accept cntb rt=9, then assert branch_is_taken in the issue cycle → issue_valid=0, a dependent on r9 is granted next cycle.
- Two ops in flight, then drain_req=1 → no grants; drained=1 after the scoreboard empties (5 cycles after the last accept); drain_req=0 returns to RUN.
